// File: rtl/aes_hex_pager.sv
// Latches a wide AES result and pages it, 4*DIGITS bits at a time, onto seven-segment digit codes.
// Optional timed auto-advance is enabled by defining AES_PAGER_AUTO_ADVANCE_EN.
module aes_hex_pager #(
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   load,
  input  logic [DATA_W-1:0]                      data_in,
  input  logic                                   next,
  input  logic                                   clear,
  output logic [4*DIGITS-1:0]                    digits,
  output logic [$clog2(DATA_W/(4*DIGITS))-1:0]   page,
  output logic                                   active,
  output logic                                   wrap
);

  localparam int unsigned PageBits = 4 * DIGITS;
  localparam int unsigned Pages    = DATA_W / PageBits;
  localparam int unsigned PageW    = $clog2(Pages);

  if ((DATA_W % PageBits) != 0 || Pages < 2) begin : g_bad_geometry
    $error("aes_hex_pager: DATA_W must be a multiple of 4*DIGITS giving at least two pages");
  end
  if (TICK_DIV < 2) begin : g_bad_tick
    $error("aes_hex_pager: TICK_DIV must be at least 2");
  end

  typedef enum logic {StIdle, StShow} state_e;

  state_e                state_q;
  logic [DATA_W-1:0]     data_q;
  logic [PageW-1:0]      page_q;
  logic                  active_q;
  logic                  wrap_q;
  logic                  tick;

`ifdef AES_PAGER_AUTO_ADVANCE_EN
  localparam int unsigned CntW = $clog2(TICK_DIV);

  logic [CntW-1:0] cnt_q;

  assign tick = (state_q == StShow) && (cnt_q == CntW'(TICK_DIV - 1));

  // Any page-changing event, or being idle, restarts the interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear || load || next || tick || (state_q != StShow)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign tick = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      data_q   <= '0;
      page_q   <= '0;
      active_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (clear) begin
        state_q  <= StIdle;
        page_q   <= '0;
        active_q <= 1'b0;
      end else if (load) begin
        state_q  <= StShow;
        data_q   <= data_in;
        page_q   <= '0;
        active_q <= 1'b1;
      end else if ((state_q == StShow) && (next || tick)) begin
        if (page_q == PageW'(Pages - 1)) begin
          page_q <= '0;
          wrap_q <= 1'b1;
        end else begin
          page_q <= page_q + 1'b1;
        end
      end
    end
  end

  // Page 0 carries the most significant nibbles; idle shows codes the decoder blanks.
  always_comb begin
    digits = '1;
    if (state_q == StShow) begin
      for (int unsigned p = 0; p < Pages; p++) begin
        if (page_q == PageW'(p)) begin
          digits = data_q[DATA_W-1-p*PageBits -: PageBits];
        end
      end
    end
  end

  assign page   = page_q;
  assign active = active_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_aes_hex_pager.sv
// Randomized and directed bench for aes_hex_pager against a page-level reference model.
module tb_aes_hex_pager;

  localparam int unsigned DATA_W   = 128;
  localparam int unsigned DIGITS   = 4;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned PAGES    = DATA_W / (4 * DIGITS);
`ifdef AES_PAGER_AUTO_ADVANCE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               load;
  logic               next_p;
  logic               clear;
  logic [DATA_W-1:0]  data_in;
  logic [15:0]        digits;
  logic [2:0]         page;
  logic               active;
  logic               wrap;

  always #5 clk = ~clk;

  aes_hex_pager #(
    .DATA_W   (DATA_W),
    .DIGITS   (DIGITS),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .data_in (data_in),
    .next    (next_p),
    .clear   (clear),
    .digits  (digits),
    .page    (page),
    .active  (active),
    .wrap    (wrap)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what is displayed, which page, and cycles since the last page event.
  bit                m_show;
  logic [DATA_W-1:0] m_data;
  int                m_page;
  int                m_cnt;
  bit                m_wrap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_digits();
    if (!m_show) return 16'hFFFF;
    return 16'(m_data >> ((PAGES - 1 - m_page) * 16));
  endfunction

  task automatic model_reset();
    m_show = 0;
    m_data = '0;
    m_page = 0;
    m_cnt  = 0;
    m_wrap = 0;
  endtask

  task automatic model_update(input bit l, input bit n, input bit c, input logic [DATA_W-1:0] d);
    bit tick;
    m_wrap = 0;
    if (c) begin
      m_show = 0;
      m_page = 0;
      m_cnt  = 0;
    end else if (l) begin
      m_show = 1;
      m_data = d;
      m_page = 0;
      m_cnt  = 0;
    end else if (m_show) begin
      tick = AUTO && (m_cnt == TICK_DIV - 1);
      if (n || tick) begin
        m_wrap = (m_page == PAGES - 1);
        m_page = (m_page + 1) % PAGES;
        m_cnt  = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".digits"}, 32'(digits), 32'(exp_digits()));
    check({tag, ".page"}, 32'(page), 32'(m_page));
    check({tag, ".active"}, 32'(active), 32'(m_show));
    check({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
  endtask

  // Called just after a falling edge: drive, take one rising edge, then compare.
  task automatic step(input bit l, input bit n, input bit c, input logic [DATA_W-1:0] d,
                      input string tag);
    load    = l;
    next_p  = n;
    clear   = c;
    data_in = d;
    @(posedge clk);
    model_update(l, n, c, d);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle(input int k, input string tag);
    for (int i = 0; i < k; i++) step(0, 0, 0, '0, tag);
  endtask

  localparam logic [DATA_W-1:0] VEC_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [DATA_W-1:0] VEC_B = 128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978;

  initial begin
    logic [15:0] want;
    int          wraps;
    int          prev;
    int          guard;

    rst = 1'b1;
    load = 0; next_p = 0; clear = 0; data_in = '0;
    model_reset();
    @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    idle(10, "idle");
    check("idle.digits_const", 32'(digits), 32'h0000FFFF);

    // Walk all pages of a known vector.
    step(1, 0, 0, VEC_A, "load_a");
    check("load_a.digits_const", 32'(digits), 32'h00000011);
    for (int p = 1; p < PAGES; p++) begin
      step(0, 1, 0, '0, "next_a");
      want = {4'(2 * p), 4'(2 * p), 4'(2 * p + 1), 4'(2 * p + 1)};
      check("next_a.digits_const", 32'(digits), 32'(want));
    end
    step(0, 1, 0, '0, "wrap_a");
    check("wrap_a.wrap_const", 32'(wrap), 32'h1);
    check("wrap_a.digits_const", 32'(digits), 32'h00000011);
    step(0, 0, 0, '0, "wrap_a_after");
    check("wrap_a.wrap_drop", 32'(wrap), 32'h0);

    // Load beats next on the same cycle.
    step(1, 0, 0, VEC_A, "reload_a");
    for (int p = 0; p < 3; p++) step(0, 1, 0, '0, "to_p3");
    step(1, 1, 0, VEC_B, "load_next");
    check("load_next.digits_const", 32'(digits), 32'h0000FEDC);
    check("load_next.page_const", 32'(page), 32'h0);

    if (AUTO) begin
      step(1, 0, 0, VEC_A, "auto_load");
      wraps = 0;
      for (int i = 0; i < 32; i++) begin
        step(0, 0, 0, '0, "auto_run");
        wraps += int'(wrap);
      end
      check("auto.wraps", 32'(wraps), 32'd1);
      check("auto.page_const", 32'(page), 32'h0);
      guard = 0;
      while (m_cnt != TICK_DIV - 1 && guard < 10) begin
        step(0, 0, 0, '0, "auto_align");
        guard++;
      end
      check("auto.align_timeout", 32'(guard < 10), 32'h1);
      prev = int'(page);
      step(0, 1, 0, '0, "tick_next");
      check("tick_next.single_step", 32'(page), 32'((prev + 1) % PAGES));
    end

    // Asynchronous reset while showing data.
    step(1, 0, 0, VEC_B, "pre_rst");
    step(0, 1, 0, '0, "pre_rst_next");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #1 rst = 1'b0;
    @(negedge clk);
    check_all("post_rst");

    // Clear on page 5, then reload.
    step(1, 0, 0, VEC_A, "clr_load");
    for (int p = 0; p < 5; p++) step(0, 1, 0, '0, "to_p5");
    step(0, 0, 1, '0, "clear");
    check("clear.digits_const", 32'(digits), 32'h0000FFFF);
    check("clear.page_const", 32'(page), 32'h0);
    step(0, 1, 0, '0, "idle_next");
    step(1, 0, 0, VEC_B, "after_clear_load");
    check("after_clear_load.page_const", 32'(page), 32'h0);

    // Random pulses and data.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(19) == 0, $urandom_range(3) == 0, $urandom_range(29) == 0,
           {$urandom, $urandom, $urandom, $urandom}, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_hex_pager.md
# aes_hex_pager

Sequencer that latches a wide AES result (key, plaintext or ciphertext) and pages it, nibble by nibble, onto a small bank of seven-segment digit decoders. The bank holds only DIGITS displays, so the block steps through DATA_W/(4·DIGITS) pages on a button pulse or an optional timer. It sits between the AES core's output register and the per-digit `seven_seg` decoder instances, and drives one 4-bit code per digit.

## Interface
- `DATA_W`, 128, width of the latched value; must be a multiple of 4·DIGITS.
- `DIGITS`, 4, number of display digits driven; PAGES = DATA_W/(4·DIGITS) ≥ 2.
- `TICK_DIV`, 50_000_000, clock cycles per automatic page advance; ≥ 2.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load`  in  1  one-cycle pulse; capture `data_in`.
- `data_in`  in  DATA_W  value to display; sampled only when `load`=1.
- `next`  in  1  one-cycle pulse (debounced upstream); advance one page.
- `clear`  in  1  one-cycle pulse; return to blank idle.
- `digits`  out  4·DIGITS  nibble per digit; digit 0 (leftmost) in the top nibble.
- `page`  out  clog2(PAGES)  index of the page shown.
- `active`  out  1  high while a value is displayed.
- `wrap`  out  1  one-cycle pulse when the page wraps from PAGES-1 to 0.

## Operation
- Registers: data (DATA_W), page, state, `wrap`; with timer configured, tick counter clog2(TICK_DIV).
- States: IDLE, SHOW.
- IDLE: `digits` = all 4'hF (the decoder blanks codes above 9), `active`=0, `page`=0. `load` → SHOW, page 0.
- SHOW: `digits` = data[DATA_W-1-page·4·DIGITS -: 4·DIGITS]; page 0 shows the most significant nibbles.
- `next` in SHOW: page+1; from PAGES-1 to 0 with `wrap`=1 for one cycle. Tick counter restarts.
- `load` in SHOW: recapture data, page=0, tick counter restarts, no `wrap`.
- `clear` in any state: → IDLE, data kept but not shown.
- Priority on the same cycle: `clear` > `load` > `next` > timer tick. A `next` and a tick in the same cycle advance one page only.
- `next` and ticks in IDLE are ignored.
- Reset values: state IDLE, `digits` all 4'hF, `page`=0, `active`=0, `wrap`=0, data 0, tick counter 0.
- Reset during SHOW: outputs drop to reset values asynchronously, with no clock edge needed.

## Timing
- All outputs are registered or decoded from registers only; no combinational path from any input.
- `load` at edge N → `active`=1, page-0 nibbles visible after edge N.
- `next` at edge N → new `page` and `digits` after edge N; `wrap` high for the cycle after edge N only.
- Timer: in SHOW the counter counts 0…TICK_DIV-1. The edge at which it holds TICK_DIV-1 advances the page and resets the counter. The result is a page change every TICK_DIV cycles with no `next`.
- `clear` at edge N → blank after edge N.

## Configuration
- `AES_PAGER_AUTO_ADVANCE_EN` defined: tick counter present; pages auto-advance every TICK_DIV cycles in SHOW, and wrap on the last page with `wrap` pulse.
- Undefined: no counter logic; `TICK_DIV` ignored; pages change only on `next`/`load`/`clear`.

## Test plan
- Reset, then idle 10 cycles → `digits`=16'hFFFF, `page`=0, `active`=0, `wrap`=0.
- `load` with data 128'h00112233_44556677_8899AABB_CCDDEEFF → next cycle `digits`=16'h0011, `page`=0, `active`=1. Each of 7 `next` pulses shows 2233, 4455, …, EEFF.
- From page 7, `next` → `digits`=16'h0011, `page`=0, `wrap`=1 for exactly one cycle.
- On page 3, `load` and `next` in the same cycle with new data 128'hFEDC… → `page`=0, `digits`=16'hFEDC, no `wrap`.
- Macro defined, TICK_DIV=4, no `next` → page increments every 4 cycles and wraps after 32 cycles. A `next` on the same cycle as a tick advances one page only.
- `rst` asserted mid-SHOW between edges → outputs return to reset values immediately. `clear` on page 5 → blank, `page`=0; a following `load` restarts at page 0.
